// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: pending-write mask plus MUL/MAC/DIV/LSU occupancy, stalling IDU1 on hazards.
// Stall is combinational from registered state only (0-cycle); completions release a stall one cycle later.
module issue_scoreboard #(
  parameter int MUL_MAX_OUTST = 2,
  parameter int DIV_LAT       = 34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        issue_valid,
  input  logic        issue_mul,
  input  logic        issue_mac,
  input  logic        issue_div,
  input  logic        issue_lsu,
  input  logic        issue_load,
  input  logic        issue_rd,
  input  logic        issue_rs1,
  input  logic        issue_rs2,
  input  logic [4:0]  issue_rd_addr,
  input  logic [4:0]  issue_rs1_addr,
  input  logic [4:0]  issue_rs2_addr,
  input  logic        mul_done,
  input  logic        mac_done,
  input  logic        div_done,
  input  logic        lsu_done,
  input  logic [4:0]  wb_rd_addr,
  input  logic        wb_rd_wr_en,
  output logic        stall,
  output logic        issue_fire,
  output logic [31:0] pending,
  output logic        mul_busy,
  output logic        mac_busy,
  output logic        div_busy,
  output logic        lsu_busy
);

  typedef enum logic {LSU_IDLE = 1'b0, LSU_BUSY = 1'b1} lsu_state_e;

  localparam logic [5:0] DivLat = 6'(DIV_LAT);
  localparam logic [2:0] MulMax = 3'(MUL_MAX_OUTST);

  logic [31:0] pending_q, pending_d;
  logic [1:0]  mul_cnt_q, mul_cnt_d;
  logic [1:0]  mac_cnt_q, mac_cnt_d;
  logic [5:0]  div_timer_q, div_timer_d;
  lsu_state_e  lsu_state_q, lsu_state_d;

  logic        is_alu;
  logic        mul_busy_int, mac_busy_int, div_busy_int, lsu_busy_int;
  logic        raw_haz, waw_haz, struct_haz, order_haz;
  logic [2:0]  mul_mac_sum;
  logic        mul_fire, mac_fire, div_fire, lsu_fire;
  logic        set_en;

  assign is_alu       = ~(issue_mul | issue_mac | issue_div | issue_lsu);
  assign mul_busy_int = (mul_cnt_q != 2'd0);
  assign mac_busy_int = (mac_cnt_q != 2'd0);
  assign div_busy_int = (div_timer_q != 6'd0);
  assign mul_mac_sum  = {1'b0, mul_cnt_q} + {1'b0, mac_cnt_q};

  // pending_q[0] is never set, so x0 operands can never raise a hazard.
  assign raw_haz    = (issue_rs1 & pending_q[issue_rs1_addr]) |
                      (issue_rs2 & pending_q[issue_rs2_addr]);
  assign waw_haz    = issue_rd & pending_q[issue_rd_addr];
  assign struct_haz = (issue_div & div_busy_int) |
                      (issue_lsu & lsu_busy_int) |
                      ((issue_mul | issue_mac) & (mul_mac_sum == MulMax));
  assign order_haz  = (~issue_div & div_busy_int) |
                      (~issue_lsu & ~is_alu & lsu_busy_int);

  // Gated by rst_n so outputs show the reset state while reset is held.
  assign stall      = rst_n & issue_valid & (raw_haz | waw_haz | struct_haz | order_haz);
  assign issue_fire = issue_valid & ~stall & ~flush;

  assign pending  = rst_n ? pending_q : 32'd0;
  assign mul_busy = rst_n & mul_busy_int;
  assign mac_busy = rst_n & mac_busy_int;
  assign div_busy = rst_n & div_busy_int;
  assign lsu_busy = rst_n & lsu_busy_int;

  assign mul_fire = issue_fire & issue_mul;
  assign mac_fire = issue_fire & issue_mac;
  assign div_fire = issue_fire & issue_div;
  assign lsu_fire = issue_fire & issue_lsu;
  assign set_en   = issue_fire & issue_rd & (issue_rd_addr != 5'd0) &
                    (issue_mul | issue_mac | issue_div | (issue_lsu & issue_load));

  always_comb begin
    pending_d = pending_q;
    if (wb_rd_wr_en) pending_d[wb_rd_addr] = 1'b0;
    if (set_en)      pending_d[issue_rd_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (mul_fire && !mul_done)
      mul_cnt_d = mul_cnt_q + 2'd1;
    else if (!mul_fire && mul_done && mul_busy_int)
      mul_cnt_d = mul_cnt_q - 2'd1;
  end

  always_comb begin
    mac_cnt_d = mac_cnt_q;
    if (mac_fire && !mac_done)
      mac_cnt_d = mac_cnt_q + 2'd1;
    else if (!mac_fire && mac_done && mac_busy_int)
      mac_cnt_d = mac_cnt_q - 2'd1;
  end

  // A fresh DIV can only fire with the timer at 0, so a coincident div_done is stale.
  always_comb begin
    div_timer_d = div_timer_q;
    if (div_fire)
      div_timer_d = DivLat;
    else if (div_done)
      div_timer_d = 6'd0;
    else if (div_busy_int)
      div_timer_d = div_timer_q - 6'd1;
  end

  always_comb begin
    lsu_state_d = lsu_state_q;
    case (lsu_state_q)
      LSU_IDLE: if (lsu_fire) lsu_state_d = LSU_BUSY;
      LSU_BUSY: if (lsu_done) lsu_state_d = LSU_IDLE;
      default:  lsu_state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    lsu_busy_int = (lsu_state_q == LSU_BUSY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q   <= 32'd0;
      mul_cnt_q   <= 2'd0;
      mac_cnt_q   <= 2'd0;
      div_timer_q <= 6'd0;
      lsu_state_q <= LSU_IDLE;
    end else begin
      pending_q   <= pending_d;
      mul_cnt_q   <= mul_cnt_d;
      mac_cnt_q   <= mac_cnt_d;
      div_timer_q <= div_timer_d;
      lsu_state_q <= lsu_state_d;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios plus random traffic against an abstract model.
module tb_issue_scoreboard;
  localparam int MUL_MAX = 2;
  localparam int DLAT    = 4;

  logic clk = 1'b0;
  logic rst_n, flush, issue_valid;
  logic issue_mul, issue_mac, issue_div, issue_lsu, issue_load;
  logic issue_rd, issue_rs1, issue_rs2;
  logic [4:0] issue_rd_addr, issue_rs1_addr, issue_rs2_addr;
  logic mul_done, mac_done, div_done, lsu_done;
  logic [4:0] wb_rd_addr;
  logic wb_rd_wr_en;
  logic stall, issue_fire;
  logic [31:0] pending;
  logic mul_busy, mac_busy, div_busy, lsu_busy;

  int n_chk = 0;
  int n_err = 0;

  issue_scoreboard #(.MUL_MAX_OUTST(MUL_MAX), .DIV_LAT(DLAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid),
    .issue_mul(issue_mul), .issue_mac(issue_mac), .issue_div(issue_div), .issue_lsu(issue_lsu),
    .issue_load(issue_load), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd_addr(issue_rd_addr), .issue_rs1_addr(issue_rs1_addr), .issue_rs2_addr(issue_rs2_addr),
    .mul_done(mul_done), .mac_done(mac_done), .div_done(div_done), .lsu_done(lsu_done),
    .wb_rd_addr(wb_rd_addr), .wb_rd_wr_en(wb_rd_wr_en),
    .stall(stall), .issue_fire(issue_fire), .pending(pending),
    .mul_busy(mul_busy), .mac_busy(mac_busy), .div_busy(div_busy), .lsu_busy(lsu_busy)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding-op counts and remaining DIV cycles as plain integers.
  logic [31:0] m_pend = '0;
  int m_mul = 0;
  int m_mac = 0;
  int m_div = 0;
  bit m_lsu = 1'b0;

  function automatic bit m_stall();
    bit alu, raw, waw, strc, ord;
    if (!issue_valid) return 1'b0;
    alu  = !(issue_mul || issue_mac || issue_div || issue_lsu);
    raw  = (issue_rs1 && m_pend[issue_rs1_addr]) || (issue_rs2 && m_pend[issue_rs2_addr]);
    waw  = issue_rd && m_pend[issue_rd_addr];
    strc = (issue_div && m_div > 0) || (issue_lsu && m_lsu) ||
           ((issue_mul || issue_mac) && (m_mul + m_mac == MUL_MAX));
    ord  = (!issue_div && m_div > 0) || (!issue_lsu && !alu && m_lsu);
    return raw || waw || strc || ord;
  endfunction

  function automatic bit m_fire();
    return issue_valid && !m_stall() && !flush;
  endfunction

  function automatic logic [31:0] nxt_pend();
    logic [31:0] p = m_pend;
    if (wb_rd_wr_en) p[wb_rd_addr] = 1'b0;
    if (m_fire() && issue_rd && issue_rd_addr != 5'd0 &&
        (issue_mul || issue_mac || issue_div || (issue_lsu && issue_load)))
      p[issue_rd_addr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic int nxt_cnt(input int c, input bit up, input bit dn);
    int n = c + int'(up);
    if (dn && n > 0) n = n - 1;
    return n;
  endfunction

  function automatic int nxt_div();
    if (m_fire() && issue_div) return DLAT;
    if (div_done) return 0;
    if (m_div > 0) return m_div - 1;
    return 0;
  endfunction

  function automatic bit nxt_lsu();
    if (!m_lsu) return m_fire() && issue_lsu;
    return !lsu_done;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend <= '0; m_mul <= 0; m_mac <= 0; m_div <= 0; m_lsu <= 1'b0;
    end else begin
      m_pend <= nxt_pend();
      m_mul  <= nxt_cnt(m_mul, m_fire() && issue_mul, mul_done);
      m_mac  <= nxt_cnt(m_mac, m_fire() && issue_mac, mac_done);
      m_div  <= nxt_div();
      m_lsu  <= nxt_lsu();
    end
  end

  task automatic idle();
    issue_valid = 0; issue_mul = 0; issue_mac = 0; issue_div = 0; issue_lsu = 0; issue_load = 0;
    issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_rd_addr = 0; issue_rs1_addr = 0; issue_rs2_addr = 0;
    mul_done = 0; mac_done = 0; div_done = 0; lsu_done = 0;
    wb_rd_addr = 0; wb_rd_wr_en = 0; flush = 0;
  endtask

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic test_reset();
    rst_n = 0; idle();
    issue_valid = 1; issue_rs1 = 1; issue_rs1_addr = 5'd3;
    smp();
    n_chk++; if ({stall, issue_fire} !== 2'b01) begin n_err++; $display("FAIL reset_fire: got %b want 01", {stall, issue_fire}); end
    n_chk++; if (pending !== 32'd0) begin n_err++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_chk++; if ({mul_busy, mac_busy, div_busy, lsu_busy} !== 4'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0000", {mul_busy, mac_busy, div_busy, lsu_busy}); end
    flush = 1; #1;
    n_chk++; if (issue_fire !== 1'b0) begin n_err++; $display("FAIL reset_flush_fire: got %b want 0", issue_fire); end
    cyc(); cyc();
    rst_n = 1; idle();
    issue_valid = 1; issue_rs1 = 1; issue_rs1_addr = 5'd3; issue_rs2 = 1; issue_rs2_addr = 5'd4;
    issue_rd = 1; issue_rd_addr = 5'd5;
    smp();
    n_chk++; if ({stall, issue_fire, pending} !== {2'b01, 32'd0}) begin n_err++; $display("FAIL post_reset: got %b/%h want 01/0", {stall, issue_fire}, pending); end
    cyc();
  endtask

  task automatic test_raw_mul();
    idle(); issue_valid = 1; issue_mul = 1; issue_rd = 1; issue_rd_addr = 5'd5; issue_rs1 = 1; issue_rs1_addr = 5'd1;
    smp();
    n_chk++; if ({stall, issue_fire} !== 2'b01) begin n_err++; $display("FAIL raw_mul_issue: got %b want 01", {stall, issue_fire}); end
    cyc();
    idle(); issue_valid = 1; issue_rs1 = 1; issue_rs1_addr = 5'd5; issue_rd = 1; issue_rd_addr = 5'd6;
    smp();
    n_chk++; if ({stall, issue_fire} !== 2'b10) begin n_err++; $display("FAIL raw_add_stall: got %b want 10", {stall, issue_fire}); end
    n_chk++; if (pending[5] !== 1'b1) begin n_err++; $display("FAIL raw_pend5: got %b want 1", pending[5]); end
    cyc();
    wb_rd_wr_en = 1; wb_rd_addr = 5'd5; mul_done = 1;
    smp();
    n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL raw_same_cycle_wb: stall got %b want 1", stall); end
    cyc();
    wb_rd_wr_en = 0; mul_done = 0;
    smp();
    n_chk++; if ({stall, issue_fire} !== 2'b01) begin n_err++; $display("FAIL raw_release: got %b want 01", {stall, issue_fire}); end
    n_chk++; if ({pending, mul_busy} !== 33'd0) begin n_err++; $display("FAIL raw_cleared: got %h/%b want 0/0", pending, mul_busy); end
    cyc();
  endtask

  task automatic test_mul_sat();
    idle(); issue_valid = 1; issue_mul = 1; issue_rd = 1; issue_rd_addr = 5'd10;
    smp();
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL sat_first: fire got %b want 1", issue_fire); end
    cyc();
    issue_rd_addr = 5'd11;
    smp();
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL sat_second: fire got %b want 1", issue_fire); end
    cyc();
    issue_rd_addr = 5'd12;
    for (int i = 0; i < 2; i++) begin
      smp();
      n_chk++; if ({stall, issue_fire, mul_busy} !== 3'b101) begin n_err++; $display("FAIL sat_third_stall[%0d]: got %b want 101", i, {stall, issue_fire, mul_busy}); end
      cyc();
    end
    mul_done = 1;
    smp();
    n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL sat_done_same_cycle: stall got %b want 1", stall); end
    cyc();
    mul_done = 0;
    smp();
    n_chk++; if ({stall, issue_fire} !== 2'b01) begin n_err++; $display("FAIL sat_third_fire: got %b want 01", {stall, issue_fire}); end
    cyc();
    issue_rd_addr = 5'd13;
    smp();
    n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL sat_cnt_two: stall got %b want 1", stall); end
    cyc();
    idle(); mul_done = 1; wb_rd_wr_en = 1; wb_rd_addr = 5'd10; cyc();
    wb_rd_addr = 5'd11; cyc();
    mul_done = 0; wb_rd_addr = 5'd12; cyc();
    idle();
    smp();
    n_chk++; if ({pending, mul_busy} !== 33'd0) begin n_err++; $display("FAIL sat_drained: got %h/%b want 0/0", pending, mul_busy); end
    cyc();
  endtask

  task automatic test_div_occupancy();
    idle(); issue_valid = 1; issue_div = 1; issue_rd = 1; issue_rd_addr = 5'd3;
    smp();
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL div_issue: fire got %b want 1", issue_fire); end
    cyc();
    idle(); issue_valid = 1; issue_rd = 1; issue_rd_addr = 5'd4; issue_rs1 = 1; issue_rs1_addr = 5'd1;
    for (int c = 1; c <= DLAT; c++) begin
      smp();
      n_chk++; if ({stall, issue_fire, div_busy} !== 3'b101) begin n_err++; $display("FAIL div_window cycle %0d: got %b want 101", c, {stall, issue_fire, div_busy}); end
      cyc();
    end
    smp();
    n_chk++; if ({stall, issue_fire, div_busy} !== 3'b010) begin n_err++; $display("FAIL div_release: got %b want 010", {stall, issue_fire, div_busy}); end
    cyc();
    idle(); wb_rd_wr_en = 1; wb_rd_addr = 5'd3; cyc();
    idle();
    smp();
    n_chk++; if (pending !== 32'd0) begin n_err++; $display("FAIL div_wb: pending got %h want 0", pending); end
    cyc();
  endtask

  task automatic test_x0();
    idle(); issue_valid = 1; issue_lsu = 1; issue_load = 1; issue_rd = 1; issue_rd_addr = 5'd0;
    smp();
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL x0_load: fire got %b want 1", issue_fire); end
    cyc();
    idle(); issue_valid = 1; issue_rs1 = 1; issue_rs1_addr = 5'd0; issue_rd = 1; issue_rd_addr = 5'd0;
    smp();
    n_chk++; if ({pending, lsu_busy} !== {32'd0, 1'b1}) begin n_err++; $display("FAIL x0_pend: got %h/%b want 0/1", pending, lsu_busy); end
    n_chk++; if ({stall, issue_fire} !== 2'b01) begin n_err++; $display("FAIL x0_add: got %b want 01", {stall, issue_fire}); end
    cyc();
    idle(); lsu_done = 1; cyc();
    idle();
    smp();
    n_chk++; if (lsu_busy !== 1'b0) begin n_err++; $display("FAIL x0_lsu_done: got %b want 0", lsu_busy); end
    cyc();
  endtask

  task automatic test_store();
    idle(); issue_valid = 1; issue_lsu = 1; issue_load = 0; issue_rd = 1; issue_rd_addr = 5'd8;
    smp();
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL store_fire: got %b want 1", issue_fire); end
    cyc();
    idle(); issue_valid = 1; issue_mul = 1;
    smp();
    n_chk++; if ({pending, lsu_busy, stall} !== {32'd0, 2'b11}) begin n_err++; $display("FAIL store_state: got %h/%b want 0/11", pending, {lsu_busy, stall}); end
    cyc();
    idle(); lsu_done = 1; cyc();
  endtask

  task automatic test_flush();
    idle(); issue_valid = 1; issue_mac = 1; issue_rd = 1; issue_rd_addr = 5'd9;
    smp();
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL flush_mac_issue: got %b want 1", issue_fire); end
    cyc();
    idle(); issue_valid = 1; issue_mul = 1; issue_rd = 1; issue_rd_addr = 5'd20; flush = 1;
    smp();
    n_chk++; if ({stall, issue_fire} !== 2'b00) begin n_err++; $display("FAIL flush_nofire: got %b want 00", {stall, issue_fire}); end
    cyc();
    idle();
    smp();
    n_chk++; if (pending !== 32'h0000_0200) begin n_err++; $display("FAIL flush_pend: got %h want 00000200", pending); end
    n_chk++; if ({mul_busy, mac_busy} !== 2'b01) begin n_err++; $display("FAIL flush_counts: got %b want 01", {mul_busy, mac_busy}); end
    cyc();
    idle(); mac_done = 1; flush = 1; wb_rd_wr_en = 1; wb_rd_addr = 5'd9; cyc();
    idle();
    smp();
    n_chk++; if ({pending, mac_busy} !== 33'd0) begin n_err++; $display("FAIL flush_mac_done: got %h/%b want 0/0", pending, mac_busy); end
    cyc();
  endtask

  task automatic test_set_clear();
    idle(); issue_valid = 1; issue_lsu = 1; issue_load = 1; issue_rd = 1; issue_rd_addr = 5'd7;
    wb_rd_wr_en = 1; wb_rd_addr = 5'd7;
    smp();
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL setclr_fire: got %b want 1", issue_fire); end
    cyc();
    idle();
    smp();
    n_chk++; if (pending !== 32'h0000_0080) begin n_err++; $display("FAIL setclr_pend7: got %h want 00000080", pending); end
    cyc();
    idle(); lsu_done = 1; wb_rd_wr_en = 1; wb_rd_addr = 5'd7; cyc();
    idle();
    smp();
    n_chk++; if ({pending, lsu_busy} !== 33'd0) begin n_err++; $display("FAIL setclr_drain: got %h/%b want 0/0", pending, lsu_busy); end
    cyc();
  endtask

  task automatic test_reset_midop();
    idle(); issue_valid = 1; issue_mul = 1; issue_rd = 1; issue_rd_addr = 5'd1; cyc();
    idle(); issue_valid = 1; issue_div = 1; issue_rd = 1; issue_rd_addr = 5'd2;
    smp();
    n_chk++; if ({issue_fire, mul_busy} !== 2'b11) begin n_err++; $display("FAIL midop_setup: got %b want 11", {issue_fire, mul_busy}); end
    cyc();
    idle(); rst_n = 0; issue_valid = 1; issue_rs1 = 1; issue_rs1_addr = 5'd2;
    smp();
    n_chk++; if ({stall, issue_fire, pending, mul_busy, div_busy} !== {2'b01, 34'd0}) begin n_err++; $display("FAIL midop_in_reset: got %b/%h/%b", {stall, issue_fire}, pending, {mul_busy, div_busy}); end
    cyc();
    rst_n = 1; idle(); issue_valid = 1; issue_rs1 = 1; issue_rs1_addr = 5'd2; issue_rs2 = 1; issue_rs2_addr = 5'd1;
    smp();
    n_chk++; if ({stall, issue_fire, pending, mul_busy, mac_busy, div_busy, lsu_busy} !== {2'b01, 36'd0}) begin n_err++; $display("FAIL midop_after: got %b/%h/%b", {stall, issue_fire}, pending, {mul_busy, mac_busy, div_busy, lsu_busy}); end
    cyc();
  endtask

  task automatic test_random();
    bit exp_stall, exp_fire;
    int sel;
    for (int c = 0; c < 600; c++) begin
      idle();
      issue_valid = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 5);
      issue_mul = (sel == 2); issue_mac = (sel == 3); issue_div = (sel == 4); issue_lsu = (sel == 5);
      issue_load = 1'($urandom_range(0, 1));
      issue_rd = ($urandom_range(0, 3) != 0);
      issue_rs1 = 1'($urandom_range(0, 1));
      issue_rs2 = 1'($urandom_range(0, 1));
      issue_rd_addr = 5'($urandom_range(0, 7));
      issue_rs1_addr = 5'($urandom_range(0, 7));
      issue_rs2_addr = 5'($urandom_range(0, 7));
      mul_done = ($urandom_range(0, 3) == 0);
      mac_done = ($urandom_range(0, 3) == 0);
      div_done = ($urandom_range(0, 15) == 0);
      lsu_done = ($urandom_range(0, 2) == 0);
      wb_rd_wr_en = ($urandom_range(0, 2) == 0);
      wb_rd_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 9) == 0);
      smp();
      exp_stall = m_stall();
      exp_fire = issue_valid && !exp_stall && !flush;
      n_chk++; if ({stall, issue_fire} !== {exp_stall, exp_fire}) begin n_err++; $display("FAIL rand_stall c%0d: got %b want %b", c, {stall, issue_fire}, {exp_stall, exp_fire}); end
      n_chk++; if (pending !== m_pend) begin n_err++; $display("FAIL rand_pending c%0d: got %h want %h", c, pending, m_pend); end
      n_chk++; if ({mul_busy, mac_busy, div_busy, lsu_busy} !== {m_mul != 0, m_mac != 0, m_div != 0, m_lsu}) begin
        n_err++; $display("FAIL rand_busy c%0d: got %b want %b", c, {mul_busy, mac_busy, div_busy, lsu_busy}, {m_mul != 0, m_mac != 0, m_div != 0, m_lsu});
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_raw_mul();
    test_mul_sat();
    test_div_occupancy();
    test_x0();
    test_store();
    test_flush();
    test_set_clear();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
